// File: rtl/rice_bus_pkg.sv
// Shared types and constants for the RICE data bus and its memory responder.
package rice_bus_pkg;

    // Width of the latency down-counter; latencies are limited to 0..7.
    localparam int LAT_W = 3;

    // Responder FSM: waits for a request, burns the configured latency, then
    // holds the response until the requester takes it.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        RESPONSE = 2'd2
    } state_t;

    // Value loaded into the down-counter when a request with latency lat > 0
    // is accepted: the WAIT state lasts exactly lat cycles.
    function automatic logic [LAT_W-1:0] wait_load(input logic [LAT_W-1:0] lat);
        return lat - LAT_W'(1);
    endfunction

endpackage

// File: rtl/rice_bus_if.sv
// Load/store data bus between the core and a memory responder.
//
// Handshake: each channel transfers on a rising edge where both its valid and
// its ready are 1. A requester holds request_valid and the request fields
// steady until the transfer; a responder holds response_valid, read_data and
// response_error steady until the transfer. Neither ready may depend on the
// other side waiting for it (no combinational ready/valid loops).
interface rice_bus_if #(
    parameter int XLEN = 32
);
    logic              request_valid;
    logic              request_ready;
    logic [XLEN-1:0]   address;
    logic              write;
    logic [XLEN-1:0]   write_data;
    logic [XLEN/8-1:0] strobe;

    logic              response_valid;
    logic              response_ready;
    logic [XLEN-1:0]   read_data;
    logic              response_error;

    modport master (
        output request_valid, address, write, write_data, strobe, response_ready,
        input  request_ready, response_valid, read_data, response_error
    );

    modport slave (
        input  request_valid, address, write, write_data, strobe, response_ready,
        output request_ready, response_valid, read_data, response_error
    );
endinterface

// File: rtl/rice_byte_enable_ram.sv
// Single-port word array with per-byte write enables and a registered read.
// The array itself is never reset; only the read register is.
module rice_byte_enable_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int NB    = DATA_W / 8,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [NB-1:0]     be,
    input  logic              re,
    input  logic [IW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write: only lanes with be[i]=1 are updated.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Registered read; the output holds its value until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/rice_data_memory.sv
// Data memory responder for the RICE load/store unit: accepts one request at a
// time, waits a per-direction latency, then presents a held response.
module rice_data_memory
    import rice_bus_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MEMORY_SIZE   = 4096,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 0
) (
    input logic       i_clk,
    input logic       i_rst,
    rice_bus_if.slave bus_if
);

    localparam int NB    = XLEN / 8;
    localparam int BW    = $clog2(NB);
    localparam int AW    = $clog2(MEMORY_SIZE);
    localparam int DEPTH = MEMORY_SIZE / NB;
    localparam int IW    = AW - BW;

    state_t            state;
    state_t            state_next;
    logic [LAT_W-1:0]  count;
    logic [LAT_W-1:0]  count_next;

    // Request captured at acceptance; the bus fields are ignored afterwards.
    logic [XLEN-1:0]   lat_addr;
    logic              lat_write;
    logic [XLEN-1:0]   lat_wdata;
    logic [NB-1:0]     lat_strobe;

    // Response flags set on the edge that enters RESPONSE.
    logic              read_valid;
    logic              resp_error;

    logic              accept;
    logic              enter_resp;
    logic              leave_resp;

    // The transaction being worked on: live bus fields while IDLE (so a
    // zero-latency access can use them on the acceptance edge), else latched.
    logic [XLEN-1:0]   cur_addr;
    logic              cur_write;
    logic [XLEN-1:0]   cur_wdata;
    logic [NB-1:0]     cur_strobe;
    logic              cur_oor;
    logic [LAT_W-1:0]  cur_lat;

    logic              ram_we;
    logic              ram_re;
    logic [IW-1:0]     ram_addr;
    logic [XLEN-1:0]   ram_rdata;

    // Select the live or latched request and derive its properties.
    always_comb begin
        cur_addr   = lat_addr;
        cur_write  = lat_write;
        cur_wdata  = lat_wdata;
        cur_strobe = lat_strobe;
        if (state == IDLE) begin
            cur_addr   = bus_if.address;
            cur_write  = bus_if.write;
            cur_wdata  = bus_if.write_data;
            cur_strobe = bus_if.strobe;
        end
        cur_oor = (cur_addr >= XLEN'(MEMORY_SIZE));
        cur_lat = cur_write ? LAT_W'(WRITE_LATENCY) : LAT_W'(READ_LATENCY);
        accept  = (state == IDLE) && bus_if.request_valid;
    end

    // Next-state logic and the one-cycle enter/leave RESPONSE strobes.
    always_comb begin
        state_next = state;
        count_next = count;
        enter_resp = 1'b0;
        leave_resp = 1'b0;
        case (state)
            IDLE: begin
                if (bus_if.request_valid) begin
                    if (cur_lat == '0) begin
                        state_next = RESPONSE;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        count_next = wait_load(cur_lat);
                    end
                end
            end
            WAIT: begin
                if (count == '0) begin
                    state_next = RESPONSE;
                    enter_resp = 1'b1;
                end else begin
                    count_next = count - LAT_W'(1);
                end
            end
            RESPONSE: begin
                if (bus_if.response_ready) begin
                    state_next = IDLE;
                    leave_resp = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // FSM state and latency counter; reset abandons any transaction in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Capture the request fields on acceptance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lat_addr   <= '0;
            lat_write  <= 1'b0;
            lat_wdata  <= '0;
            lat_strobe <= '0;
        end else if (accept) begin
            lat_addr   <= bus_if.address;
            lat_write  <= bus_if.write;
            lat_wdata  <= bus_if.write_data;
            lat_strobe <= bus_if.strobe;
        end
    end

    // Response flags: read data is only passed through for in-range reads.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            read_valid <= 1'b0;
            resp_error <= 1'b0;
        end else if (enter_resp) begin
            read_valid <= !cur_write && !cur_oor;
            resp_error <= cur_oor;
        end else if (leave_resp) begin
            read_valid <= 1'b0;
            resp_error <= 1'b0;
        end
    end

    // Array access happens only on the edge that enters RESPONSE; reset
    // blocks it so an interrupted write never lands.
    always_comb begin
        ram_we   = enter_resp && cur_write && !cur_oor && !i_rst;
        ram_re   = enter_resp && !cur_write && !cur_oor && !i_rst;
        ram_addr = cur_addr[AW-1:BW];
    end

    rice_byte_enable_ram #(
        .DATA_W (XLEN),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (i_clk),
        .rst   (i_rst),
        .we    (ram_we),
        .be    (cur_strobe),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    assign bus_if.request_ready  = (state == IDLE);
    assign bus_if.response_valid = (state == RESPONSE);
    assign bus_if.read_data      = read_valid ? ram_rdata : '0;
    assign bus_if.response_error = resp_error;

endmodule
